mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Initiator side of the data-RAM interface: accepts one load/store request at a time from the MEM pipeline stage and drives the byte-lane RAM port (ram_en, wr_en, Bits_Sel, address, write data).
- Captures read data, performs lane extraction and sign/zero extension, and returns one response per request.
- Sits between the MEM stage and the data RAM; it is the only master of that RAM port.

Parameters:
- RD_LAT, 0, extra wait cycles held in ACCESS before sampling data_from_ram on loads (0..15).
- DW, 32, data/address width; fixed at 32 for this design.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_op  in  3  0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- req_tag  in  5  destination register tag, echoed back
- resp_valid  out  1  one-cycle response strobe; no backpressure
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_tag  out  5  echoed tag
- resp_err  out  1  misaligned-access error
- resp_badaddr  out  32  offending address when resp_err=1, else 0
- busy  out  1  state != IDLE
- ram_en  out  1  RAM enable
- wr_en  out  1  1 = write, 0 = read
- Bits_Sel  out  4  byte-lane enables; bit3 = data[31:24]
- ram_addr_o  out  32  word-aligned byte address (bits [1:0] = 00)
- data_to_ram  out  32  lane-replicated store data
- data_from_ram  in  32  combinational read data from RAM

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 except req_ready=1. Reset mid-operation aborts the request with no response. A write edge that has already occurred is not undone.
- All RAM-side and response outputs are registered.
- **IDLE**
  - req_ready=1; RAM outputs 0.
  - On req_valid&&req_ready: latch op, addr, wdata and tag, then check alignment.
  - Misaligned cases: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0. These go to RESP with err=1 and make no RAM access.
  - Otherwise go to ACCESS.
- **ACCESS**
  - ram_en=1; ram_addr_o={addr[31:2],2'b00}.
  - Lanes are big-endian: offset 0 -> Bits_Sel 1000, 1 -> 0100, 2 -> 0010, 3 -> 0001. Halfword offset 0 -> 1100, offset 2 -> 0011. Word -> 1111.
  - Store: wr_en=1; data_to_ram = SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata. Held exactly one cycle (one write edge), then RESP.
  - Load: wr_en=0; Bits_Sel as for the equivalent width. ACCESS lasts 1+RD_LAT cycles, counted by a 4-bit down-counter. data_from_ram is sampled on the last cycle, then RESP.
- **RESP**
  - resp_valid=1 for exactly one cycle; RAM outputs back to 0; then IDLE.
  - Load extraction: select byte/halfword by addr[1:0] (big-endian). LB/LH sign-extend; LBU/LHU zero-extend.
- req_ready=0 in ACCESS and RESP. A req_valid arriving then is ignored and must be held by the requester.
- Throughput: store and aligned load (RD_LAT=0) take 3 cycles per request (accept, ACCESS, RESP). The next accept happens in the cycle after RESP.
- Error latency: 2 cycles (accept, RESP).

Test Plan:
- SW addr 0x100 wdata 0xDEADBEEF -> ACCESS: ram_en=1, wr_en=1, Bits_Sel=1111, ram_addr_o=0x100, data_to_ram=0xDEADBEEF; next cycle resp_valid=1, resp_err=0, resp_rdata=0.
- SB addr 0x101 wdata 0x000000A5 -> Bits_Sel=0100, data_to_ram=0xA5A5A5A5, ram_addr_o=0x100; a following LW 0x100 returns 0xDEA5BEEF.
- RAM word 0x80F0_7F01 at 0x200: LB 0x200 -> 0xFFFFFF80; LBU 0x200 -> 0x00000080; LH 0x202 -> 0x00007F01; LHU 0x200 -> 0x000080F0; resp_tag echoes 5'd9.
- LW 0x202 and SH 0x203 -> resp_err=1, resp_badaddr = the address, ram_en never asserted, resp two cycles after accept.
- RD_LAT=3: LW 0x200 -> ram_en/address held 4 cycles; data changed on the RAM before the last ACCESS cycle is the value returned; busy=1 throughout; req_ready=0 while a second req_valid is held.
- rst_n pulsed low during a load ACCESS -> outputs 0 immediately, no resp_valid; the next request completes normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for the byte-lane data RAM: one request in flight, big-endian lanes,
// registered RAM and response outputs, misaligned accesses answered without touching the RAM.
module mem_access_ctrl #(
  parameter int unsigned RD_LAT = 0,
  parameter int unsigned DW     = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_op,
  input  logic [DW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [4:0]    req_tag,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic [4:0]    resp_tag,
  output logic          resp_err,
  output logic [DW-1:0] resp_badaddr,
  output logic          busy,
  output logic          ram_en,
  output logic          wr_en,
  output logic [3:0]    Bits_Sel,
  output logic [DW-1:0] ram_addr_o,
  output logic [DW-1:0] data_to_ram,
  input  logic [DW-1:0] data_from_ram
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;
  typedef enum logic [2:0] {OpLb, OpLh, OpLw, OpLbu, OpLhu, OpSb, OpSh, OpSw} op_e;

  function automatic logic is_store(op_e op);
    return op inside {OpSb, OpSh, OpSw};
  endfunction

  function automatic logic misaligned(op_e op, logic [1:0] off);
    case (op)
      OpLh, OpLhu, OpSh: misaligned = off[0];
      OpLw, OpSw:        misaligned = |off;
      default:           misaligned = 1'b0;
    endcase
  endfunction

  // Offset 0 is the most significant byte lane.
  function automatic logic [3:0] lane_sel(op_e op, logic [1:0] off);
    case (op)
      OpLb, OpLbu, OpSb: lane_sel = 4'b1000 >> off;
      OpLh, OpLhu, OpSh: lane_sel = off[1] ? 4'b0011 : 4'b1100;
      default:           lane_sel = 4'b1111;
    endcase
  endfunction

  function automatic logic [DW-1:0] store_data(op_e op, logic [DW-1:0] w);
    case (op)
      OpSb:    store_data = {4{w[7:0]}};
      OpSh:    store_data = {2{w[15:0]}};
      OpSw:    store_data = w;
      default: store_data = '0;
    endcase
  endfunction

  function automatic logic [DW-1:0] extract(op_e op, logic [1:0] off, logic [DW-1:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = d[31:24];
      2'd1:    b = d[23:16];
      2'd2:    b = d[15:8];
      default: b = d[7:0];
    endcase
    h = off[1] ? d[15:0] : d[31:16];
    case (op)
      OpLb:    extract = {{24{b[7]}}, b};
      OpLbu:   extract = {24'd0, b};
      OpLh:    extract = {{16{h[15]}}, h};
      OpLhu:   extract = {16'd0, h};
      default: extract = d;
    endcase
  endfunction

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [1:0]    off_q, off_d;
  logic [4:0]    tag_q, tag_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          ram_en_q, ram_en_d;
  logic          wr_en_q, wr_en_d;
  logic [3:0]    bits_sel_q, bits_sel_d;
  logic [DW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          resp_valid_q, resp_valid_d;
  logic [DW-1:0] resp_rdata_q, resp_rdata_d;
  logic [4:0]    resp_tag_q, resp_tag_d;
  logic          resp_err_q, resp_err_d;
  logic [DW-1:0] resp_badaddr_q, resp_badaddr_d;

  op_e in_op;
  assign in_op = op_e'(req_op);

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    off_d          = off_q;
    tag_d          = tag_q;
    cnt_d          = cnt_q;
    ram_en_d       = 1'b0;
    wr_en_d        = 1'b0;
    bits_sel_d     = 4'b0000;
    ram_addr_d     = '0;
    wdata_d        = '0;
    resp_valid_d   = 1'b0;
    resp_rdata_d   = '0;
    resp_tag_d     = '0;
    resp_err_d     = 1'b0;
    resp_badaddr_d = '0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d  = in_op;
          off_d = req_addr[1:0];
          tag_d = req_tag;
          if (misaligned(in_op, req_addr[1:0])) begin
            state_d        = StResp;
            resp_valid_d   = 1'b1;
            resp_err_d     = 1'b1;
            resp_badaddr_d = req_addr;
            resp_tag_d     = req_tag;
          end else begin
            state_d    = StAccess;
            ram_en_d   = 1'b1;
            wr_en_d    = is_store(in_op);
            bits_sel_d = lane_sel(in_op, req_addr[1:0]);
            ram_addr_d = {req_addr[DW-1:2], 2'b00};
            wdata_d    = store_data(in_op, req_wdata);
            cnt_d      = is_store(in_op) ? 4'd0 : 4'(RD_LAT);
          end
        end
      end
      StAccess: begin
        if (wr_en_q || cnt_q == 4'd0) begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
          resp_tag_d   = tag_q;
          if (!wr_en_q) resp_rdata_d = extract(op_q, off_q, data_from_ram);
        end else begin
          cnt_d      = cnt_q - 4'd1;
          ram_en_d   = ram_en_q;
          wr_en_d    = wr_en_q;
          bits_sel_d = bits_sel_q;
          ram_addr_d = ram_addr_q;
          wdata_d    = wdata_q;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      op_q           <= OpLb;
      off_q          <= 2'd0;
      tag_q          <= 5'd0;
      cnt_q          <= 4'd0;
      ram_en_q       <= 1'b0;
      wr_en_q        <= 1'b0;
      bits_sel_q     <= 4'b0000;
      ram_addr_q     <= '0;
      wdata_q        <= '0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= '0;
      resp_tag_q     <= 5'd0;
      resp_err_q     <= 1'b0;
      resp_badaddr_q <= '0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      off_q          <= off_d;
      tag_q          <= tag_d;
      cnt_q          <= cnt_d;
      ram_en_q       <= ram_en_d;
      wr_en_q        <= wr_en_d;
      bits_sel_q     <= bits_sel_d;
      ram_addr_q     <= ram_addr_d;
      wdata_q        <= wdata_d;
      resp_valid_q   <= resp_valid_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_tag_q     <= resp_tag_d;
      resp_err_q     <= resp_err_d;
      resp_badaddr_q <= resp_badaddr_d;
    end
  end

  assign req_ready    = (state_q == StIdle);
  assign busy         = (state_q != StIdle);
  assign ram_en       = ram_en_q;
  assign wr_en        = wr_en_q;
  assign Bits_Sel     = bits_sel_q;
  assign ram_addr_o   = ram_addr_q;
  assign data_to_ram  = wdata_q;
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_tag     = resp_tag_q;
  assign resp_err     = resp_err_q;
  assign resp_badaddr = resp_badaddr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed cases plus random traffic against a byte-level RAM model.
module tb_mem_access_ctrl;

  localparam int unsigned RdLat = 3;

  logic        clk, rst_n;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_tag;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, resp_badaddr;
  logic [4:0]  resp_tag;
  logic        busy, ram_en, wr_en;
  logic [3:0]  Bits_Sel;
  logic [31:0] ram_addr_o, data_to_ram, data_from_ram;

  int checks = 0;
  int errors = 0;

  mem_access_ctrl #(.RD_LAT(RdLat), .DW(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_tag       (req_tag),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_tag      (resp_tag),
    .resp_err      (resp_err),
    .resp_badaddr  (resp_badaddr),
    .busy          (busy),
    .ram_en        (ram_en),
    .wr_en         (wr_en),
    .Bits_Sel      (Bits_Sel),
    .ram_addr_o    (ram_addr_o),
    .data_to_ram   (data_to_ram),
    .data_from_ram (data_from_ram)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: 256 words aliased over the address space, plus a backdoor write port.
  logic [31:0] mem [256];
  logic        bd_we;
  logic [7:0]  bd_idx;
  logic [31:0] bd_data;

  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    else if (ram_en && wr_en)
      for (int i = 0; i < 4; i++)
        if (Bits_Sel[i]) mem[ram_addr_o[9:2]][8*i +: 8] <= data_to_ram[8*i +: 8];
  end
  assign data_from_ram = mem[ram_addr_o[9:2]];

  logic [31:0] ref_mem [256];

  function automatic int op_size(input logic [2:0] op);
    case (op)
      3'd0, 3'd3, 3'd5: return 1;
      3'd1, 3'd4, 3'd6: return 2;
      default:          return 4;
    endcase
  endfunction

  function automatic logic [3:0] exp_lanes(input logic [2:0] op, input logic [31:0] addr);
    int size = op_size(op);
    int off  = int'(addr[1:0]);
    return 4'(((1 << size) - 1) << (4 - size - off));
  endfunction

  function automatic logic [31:0] exp_store(input logic [2:0] op, input logic [31:0] w);
    case (op_size(op))
      1:       return 32'(w[7:0]) * 32'h0101_0101;
      2:       return 32'(w[15:0]) * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] op, input logic [31:0] addr,
                                           input logic [31:0] word);
    int size = op_size(op);
    int bits = 8 * size;
    int off  = int'(addr[1:0]);
    logic [31:0] mask, v;
    if (size == 4) return word;
    mask = (32'd1 << bits) - 32'd1;
    v = (word >> ((4 - size - off) * 8)) & mask;
    if ((op == 3'd0 || op == 3'd1) && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] lanes,
                                        input logic [31:0] d);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (lanes[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] idx, input logic [31:0] v);
    bd_we = 1'b1; bd_idx = idx; bd_data = v;
    ref_mem[idx] = v;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  // One request from accept to the idle cycle after its response. Optionally overwrite the
  // target word mid-access and keep a second request pending while busy.
  task automatic run_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] tag, input bit poke_mid, input logic [31:0] poke_val,
                         input bit hold_next, output logic [31:0] got);
    int size = op_size(op);
    bit err  = (int'(addr[1:0]) % size) != 0;
    bit st   = op >= 3'd5;
    logic [7:0]  idx = addr[9:2];
    logic [31:0] exp_rd;
    int lat, en_cnt, n;

    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata; req_tag = tag;
    @(posedge clk); #1;
    if (hold_next) begin
      req_op = 3'd7; req_addr = 32'h300; req_wdata = $urandom(); req_tag = ~tag;
    end else req_valid = 1'b0;

    if (!err) begin
      check("access_ram_en", 32'(ram_en), 32'd1);
      check("access_wr_en", 32'(wr_en), 32'(st));
      check("access_bits_sel", 32'(Bits_Sel), 32'(exp_lanes(op, addr)));
      check("access_addr", ram_addr_o, {addr[31:2], 2'b00});
      check("access_wdata", data_to_ram, st ? exp_store(op, wdata) : 32'd0);
    end
    if (poke_mid && !err) begin
      bd_we = 1'b1; bd_idx = idx; bd_data = poke_val;
      ref_mem[idx] = poke_val;
    end
    exp_rd = (err || st) ? 32'd0 : exp_load(op, addr, ref_mem[idx]);
    if (st && !err) ref_mem[idx] = merge(ref_mem[idx], exp_lanes(op, addr), exp_store(op, wdata));
    lat = err ? 1 : (st ? 2 : 2 + int'(RdLat));

    n = 1; en_cnt = 0;
    while (!resp_valid && n < 40) begin
      if (ram_en) en_cnt++;
      if (hold_next) begin
        check("held_req_ready", 32'(req_ready), 32'd0);
        check("held_busy", 32'(busy), 32'd1);
      end
      @(posedge clk); #1;
      n++;
      bd_we = 1'b0;
    end
    check("latency", n, lat);
    check("ram_en_cycles", en_cnt, err ? 0 : lat - 1);
    check("resp_valid", 32'(resp_valid), 32'd1);
    check("resp_err", 32'(resp_err), 32'(err));
    check("resp_rdata", resp_rdata, exp_rd);
    check("resp_tag", 32'(resp_tag), 32'(tag));
    check("resp_badaddr", resp_badaddr, err ? addr : 32'd0);
    check("resp_ram_en", 32'(ram_en), 32'd0);
    check("resp_req_ready", 32'(req_ready), 32'd0);
    got = resp_rdata;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("after_resp_valid", 32'(resp_valid), 32'd0);
    check("after_req_ready", 32'(req_ready), 32'd1);
    check("after_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] got, a, w;
    logic [2:0]  op;
    logic [4:0]  tg;

    rst_n = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0; req_tag = '0;
    bd_we = 1'b0; bd_idx = '0; bd_data = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_bits_sel", 32'(Bits_Sel), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 256; i++) poke(8'(i), $urandom());

    run_req(3'd7, 32'h100, 32'hDEAD_BEEF, 5'd1, 1'b0, 32'd0, 1'b0, got);
    run_req(3'd5, 32'h101, 32'h0000_00A5, 5'd2, 1'b0, 32'd0, 1'b0, got);
    run_req(3'd2, 32'h100, 32'd0, 5'd3, 1'b0, 32'd0, 1'b0, got);
    check("lw_after_sb", got, 32'hDEA5_BEEF);

    poke(8'h80, 32'h80F0_7F01);
    run_req(3'd0, 32'h200, 32'd0, 5'd9, 1'b0, 32'd0, 1'b0, got);
    check("lb_sign", got, 32'hFFFF_FF80);
    run_req(3'd3, 32'h200, 32'd0, 5'd9, 1'b0, 32'd0, 1'b0, got);
    check("lbu_zero", got, 32'h0000_0080);
    run_req(3'd1, 32'h202, 32'd0, 5'd9, 1'b0, 32'd0, 1'b0, got);
    check("lh_low", got, 32'h0000_7F01);
    run_req(3'd4, 32'h200, 32'd0, 5'd9, 1'b0, 32'd0, 1'b0, got);
    check("lhu_high", got, 32'h0000_80F0);

    run_req(3'd2, 32'h202, 32'd0, 5'd4, 1'b0, 32'd0, 1'b0, got);
    run_req(3'd6, 32'h203, 32'h1234, 5'd5, 1'b0, 32'd0, 1'b0, got);

    // Word rewritten after the first access cycle; the late sample must see the new value.
    run_req(3'd2, 32'h200, 32'd0, 5'd9, 1'b1, 32'h1234_5678, 1'b1, got);
    check("late_sample", got, 32'h1234_5678);

    // Reset during a load access: abort with no response.
    req_valid = 1'b1; req_op = 3'd2; req_addr = 32'h200; req_tag = 5'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("pre_rst_ram_en", 32'(ram_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_ram_en", 32'(ram_en), 32'd0);
    check("midrst_addr", ram_addr_o, 32'd0);
    check("midrst_bits_sel", 32'(Bits_Sel), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("midrst_no_resp", 32'(resp_valid), 32'd0);
      @(posedge clk); #1;
    end
    run_req(3'd2, 32'h100, 32'd0, 5'd11, 1'b0, 32'd0, 1'b0, got);

    for (int i = 0; i < 100; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom();
      w  = $urandom();
      tg = 5'($urandom_range(0, 31));
      run_req(op, a, w, tg, 1'b0, 32'd0, 1'b0, got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
